fetch_unit: RTL

Parametrised instruction-fetch front end that replaces the single-cycle PC register, PC incrementer and halt-hold logic of the 5-stage pipeline's IF stage. It issues pipelined requests to an instruction memory with arbitrary, in-order response latency. Returned instructions are buffered in a prefetch FIFO and handed to decode through a valid/ready handshake. Branch redirects flush the FIFO and discard in-flight responses, and a fetched HLT opcode stops further fetching.

---
 rtl/fetch_pkg.sv | 7 +
 rtl/fetch_fifo.sv | 35 +++
 rtl/fetch_unit.sv | 75 +++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared defaults and FSM state type for the fetch front end
package fetch_pkg;
  localparam int DEF_INSTR_BYTES = 2;
  localparam logic [15:0] DEF_RESET_PC = 16'h0000;
  localparam logic [3:0] DEF_HALT_OPCODE = 4'hF;
  typedef enum logic {RUN, HALTED} state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch queue with flop storage, wrap-bit pointers and synchronous clear
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) mem[wr_ptr[AW-1:0]] <= din;
      if (push) wr_ptr <= wr_ptr + ONE;
      if (pop) rd_ptr <= rd_ptr + ONE;
    end
  end
  assign head = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: pipelined instruction fetch with prefetch FIFO, redirect flush and halt
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH = 4,
  parameter int INSTR_BYTES = DEF_INSTR_BYTES,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
  parameter logic [3:0] HALT_OPCODE = DEF_HALT_OPCODE
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc_next,
  output logic              halted
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] INC = ADDR_W'(INSTR_BYTES);
  state_t state, state_nx;
  logic [ADDR_W-1:0] fetch_pc, resp_pc;
  logic [CW-1:0] outstanding, drop_cnt, fifo_count, out_nx;
  logic [CW:0] occupancy;
  logic [DATA_W+ADDR_W-1:0] head;
  logic gnt, pop, accept, hlt;
  assign pop = out_valid & out_ready;
  assign occupancy = {1'b0, outstanding} + {1'b0, fifo_count} - {{CW{1'b0}}, pop};
  assign imem_req = rst_n & (state == RUN) & ~redirect_valid & (occupancy < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc;
  assign gnt = imem_req & imem_gnt;
  assign out_nx = outstanding + {{(CW-1){1'b0}}, gnt} - {{(CW-1){1'b0}}, imem_rvalid};
  assign accept = imem_rvalid & (drop_cnt == '0) & ~redirect_valid;
  assign hlt = accept & (imem_rdata[DATA_W-1 -: 4] == HALT_OPCODE);
  assign out_valid = fifo_count != '0;
  assign {out_instr, out_pc_next} = head;
  assign halted = state == HALTED;
  always_comb state_nx = redirect_valid ? RUN : hlt ? HALTED : state;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      resp_pc <= RESET_PC;
      outstanding <= '0;
      drop_cnt <= '0;
    end else begin
      outstanding <= out_nx;
      fetch_pc <= redirect_valid ? redirect_pc : gnt ? fetch_pc + INC : fetch_pc;
      resp_pc <= redirect_valid ? redirect_pc : accept ? resp_pc + INC : resp_pc;
      drop_cnt <= (redirect_valid | hlt) ? out_nx :
                  (imem_rvalid && drop_cnt != '0) ? drop_cnt - CW'(1) : drop_cnt;
    end
  end
  fetch_fifo #(.WIDTH(DATA_W + ADDR_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .clear(redirect_valid),
    .push(accept),
    .pop(pop & ~redirect_valid),
    .din({imem_rdata, resp_pc + INC}),
    .head(head),
    .count(fifo_count)
  );
endmodule
